// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants used by fetch and controller,
// plus the fetch sequencer state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } fetch_state_t;

    // True for opcodes the fetch unit resolves itself.
    function automatic logic is_flow_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment,
// increment wraps naturally at 2^ADDR_W.
module program_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              increment,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] pc
);

    // Jump target load wins over the post-fetch increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (increment) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: fetches one word per FETCH/EXEC pair,
// resolves JMP/HLT locally and strobes the opcode to the controller.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_valid,
    output logic [3:0]         opcode,
    output logic [INSTR_W-5:0] operand,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    localparam int OPND_W = INSTR_W - 4;

    fetch_state_t       state;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         ir_op;
    logic               fetch_done;
    logic               jmp_take;
    logic [ADDR_W-1:0]  jmp_target;

    assign ir_op      = ir[INSTR_W-1 -: 4];
    assign fetch_done = mem_req && mem_valid;
    assign jmp_take   = instr_valid && is_flow_op(ir_op)
                        && (ir_op == OP_JMP);
    assign jmp_target = ADDR_W'(ir[OPND_W-1:0]);

    // Outputs decode straight from state so reset clears them at once.
    assign mem_req     = (state == S_FETCH);
    assign instr_valid = (state == S_EXEC);
    assign halted      = (state == S_HALT);
    assign mem_addr    = pc;
    assign opcode      = instr_valid ? ir_op : OP_NOP;
    assign operand     = ir[OPND_W-1:0];

    // Sequencer: an open request always completes, run only gates new ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_valid) begin
                        ir    <= mem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ir_op == OP_HLT) begin
                        state <= S_HALT;
                    end else if (run) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    program_counter #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (jmp_take),
        .increment (fetch_done),
        .load_value(jmp_target),
        .pc        (pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random programs
// checked against an instruction-level model of the fetch unit.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_valid = 1'b0;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid;
    logic [7:0] pc;
    logic       halted;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [256];
    bit resp_en = 1'b1;
    int wait_cfg = 0;
    int wait_cur = 0;
    int wcnt = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W (8),
        .INSTR_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .opcode     (opcode),
        .operand    (operand),
        .instr_valid(instr_valid),
        .pc         (pc),
        .halted     (halted)
    );

    // Memory responder: answers each request after wait_cur cycles.
    always @(negedge clk) begin
        if (resp_en) begin
            if (mem_req) begin
                if (wcnt >= wait_cur) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_valid = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_valid = 1'b0;
                wcnt = 0;
                if (wait_cfg < 0) wait_cur = $urandom_range(0, 3);
                else wait_cur = wait_cfg;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] plain_word();
        return {4'($urandom_range(0, 13)), 4'($urandom_range(0, 15))};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: req=%b iv=%b h=%b want 0 0 0",
                     mem_req, instr_valid, halted);
        end
        total++;
        if (mem_addr !== 8'h00 || pc !== 8'h00) begin
            bad++;
            $display("FAIL reset_pc: addr=%h pc=%h want 00", mem_addr, pc);
        end
        total++;
        if (opcode !== 4'h0 || operand !== 4'h0) begin
            bad++;
            $display("FAIL reset_ir: op=%h opd=%h want 0", opcode, operand);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        mem[0] = 8'h1A;
        mem[1] = 8'h00;
        wait_cfg = 0;
        do_reset();
        run = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || opcode !== 4'h0) begin
            bad++;
            $display("FAIL ff_req: req=%b addr=%h op=%h want 1 00 0",
                     mem_req, mem_addr, opcode);
        end
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b1 || opcode !== 4'h1 || operand !== 4'hA) begin
            bad++;
            $display("FAIL ff_exec: iv=%b op=%h opd=%h want 1 1 a",
                     instr_valid, opcode, operand);
        end
        total++;
        if (pc !== 8'h01) begin
            bad++;
            $display("FAIL ff_pc: pc=%h want 01", pc);
        end
        run = 1'b0;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0 || opcode !== 4'h0) begin
            bad++;
            $display("FAIL ff_strobe: iv=%b op=%h want 0 0", instr_valid, opcode);
        end
    endtask

    task automatic test_wait_states();
        int n;
        int nreq;
        bit unstable;
        mem[0] = plain_word();
        wait_cfg = 3;
        do_reset();
        run = 1'b1;
        @(negedge clk);
        n = 0;
        nreq = 0;
        unstable = 1'b0;
        while (!instr_valid && n < 20) begin
            if (mem_req) nreq++;
            if (mem_addr !== 8'h00 || opcode !== 4'h0) unstable = 1'b1;
            @(negedge clk);
            n++;
        end
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL ws_timeout: iv=%b want 1", instr_valid);
        end
        total++;
        if (nreq != 4 || unstable) begin
            bad++;
            $display("FAIL ws_req: cycles=%0d unstable=%b want 4 0",
                     nreq, unstable);
        end
        total++;
        if (opcode !== mem[0][7:4] || operand !== mem[0][3:0]) begin
            bad++;
            $display("FAIL ws_word: got=%h%h want %h", opcode, operand, mem[0]);
        end
        run = 1'b0;
        wait_cfg = 0;
    endtask

    task automatic test_jmp();
        int n;
        logic [7:0] last;
        bit found;
        for (int i = 0; i < 16; i++) mem[8'(i)] = plain_word();
        mem[16] = 8'hE5;
        do_reset();
        run = 1'b1;
        n = 0;
        last = 8'h00;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_req) last = mem_addr;
            else if (instr_valid && last == 8'h10) found = 1'b1;
        end
        total++;
        if (!found || opcode !== 4'hE || operand !== 4'h5) begin
            bad++;
            $display("FAIL jmp_exec: found=%b op=%h opd=%h want 1 e 5",
                     found, opcode, operand);
        end
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h05 || pc !== 8'h05) begin
            bad++;
            $display("FAIL jmp_target: req=%b addr=%h pc=%h want 1 05 05",
                     mem_req, mem_addr, pc);
        end
        run = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        logic [7:0] last;
        bit found;
        for (int i = 0; i < 256; i++) mem[8'(i)] = plain_word();
        mem[255] = 8'h00;
        do_reset();
        run = 1'b1;
        n = 0;
        last = 8'h00;
        found = 1'b0;
        while (!found && n < 1200) begin
            @(negedge clk);
            n++;
            if (mem_req) last = mem_addr;
            else if (instr_valid && last == 8'hFF) found = 1'b1;
        end
        total++;
        if (!found || opcode !== 4'h0 || pc !== 8'h00) begin
            bad++;
            $display("FAIL wrap_pc: found=%b op=%h pc=%h want 1 0 00",
                     found, opcode, pc);
        end
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL wrap_addr: req=%b addr=%h want 1 00",
                     mem_req, mem_addr);
        end
        run = 1'b0;
    endtask

    task automatic test_halt();
        int n;
        int stray;
        mem[0] = 8'hF0;
        mem[1] = plain_word();
        do_reset();
        run = 1'b1;
        n = 0;
        while (!instr_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (instr_valid !== 1'b1 || opcode !== 4'hF) begin
            bad++;
            $display("FAIL hlt_exec: iv=%b op=%h want 1 f", instr_valid, opcode);
        end
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || mem_req !== 1'b0 || opcode !== 4'h0) begin
            bad++;
            $display("FAIL hlt_state: h=%b req=%b op=%h want 1 0 0",
                     halted, mem_req, opcode);
        end
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req || instr_valid || !halted) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL hlt_hold: stray=%0d want 0", stray);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (halted !== 1'b0 || pc !== 8'h00) begin
            bad++;
            $display("FAIL hlt_reset: h=%b pc=%h want 0 00", halted, pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || halted !== 1'b0) begin
            bad++;
            $display("FAIL hlt_restart: req=%b addr=%h h=%b want 1 00 0",
                     mem_req, mem_addr, halted);
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        int stray;
        resp_en = 1'b0;
        mem_valid = 1'b0;
        do_reset();
        run = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_req: req=%b want 1", mem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL mid_drop: req=%b want 0", mem_req);
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 8'hF0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_req || instr_valid || halted) stray++;
        end
        total++;
        if (stray != 0 || pc !== 8'h00 || operand !== 4'h0) begin
            bad++;
            $display("FAIL mid_late: stray=%0d pc=%h opd=%h want 0 00 0",
                     stray, pc, operand);
        end
        mem_valid = 1'b0;
        resp_en = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] exp_pc;
        logic [7:0] w;
        bit exp_halt;
        bit prev_iv;
        int nexec;
        int r;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 39);
                if (r == 0) mem[8'(i)] = {4'hF, 4'($urandom)};
                else if (r < 5) mem[8'(i)] = {4'hE, 4'($urandom)};
                else mem[8'(i)] = plain_word();
            end
            wait_cfg = -1;
            do_reset();
            exp_pc = 8'h00;
            exp_halt = 1'b0;
            prev_iv = 1'b0;
            nexec = 0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                run = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                total++;
                if (halted !== exp_halt) begin
                    bad++;
                    $display("FAIL rnd_halt: h=%b want %b", halted, exp_halt);
                end
                total++;
                if (instr_valid && prev_iv) begin
                    bad++;
                    $display("FAIL rnd_strobe: iv=1 twice want single");
                end
                prev_iv = instr_valid;
                if (mem_req) begin
                    total++;
                    if (mem_addr !== exp_pc) begin
                        bad++;
                        $display("FAIL rnd_addr: addr=%h want %h",
                                 mem_addr, exp_pc);
                    end
                end
                if (instr_valid) begin
                    w = mem[exp_pc];
                    nexec++;
                    total++;
                    if (opcode !== w[7:4] || operand !== w[3:0]) begin
                        bad++;
                        $display("FAIL rnd_word: got=%h%h want %h",
                                 opcode, operand, w);
                    end
                    total++;
                    if (pc !== 8'(exp_pc + 8'd1)) begin
                        bad++;
                        $display("FAIL rnd_pc: pc=%h want %h",
                                 pc, 8'(exp_pc + 8'd1));
                    end
                    if (w[7:4] == 4'hE) exp_pc = {4'h0, w[3:0]};
                    else exp_pc = 8'(exp_pc + 8'd1);
                    if (w[7:4] == 4'hF) exp_halt = 1'b1;
                end else begin
                    total++;
                    if (opcode !== 4'h0) begin
                        bad++;
                        $display("FAIL rnd_op0: op=%h want 0", opcode);
                    end
                end
            end
            total++;
            if (nexec < 10 && !exp_halt) begin
                bad++;
                $display("FAIL rnd_progress: execs=%0d want >=10", nexec);
            end
        end
        run = 1'b0;
        wait_cfg = 0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_jmp();
        test_wrap();
        test_halt();
        test_reset_mid_fetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
